// File: rtl/spi_word_receiver.sv
// spi_word_receiver: SPI mode-0 slave that oversamples sck/sdi/cs_n and captures one BITS-wide word per frame
module spi_word_receiver #(
    parameter int BITS        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sck,
    input  logic            sdi,
    input  logic            cs_n,
    output logic [BITS-1:0] data,
    output logic            valid,
    output logic            frame_err,
    output logic            busy
);
    localparam int CW = $clog2(BITS + 2);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   cs_dly_q, cs_dly_d;
    logic [0:0]             state_q, state_d;
    logic [BITS-1:0]        shift_q, shift_d;
    logic [CW-1:0]          count_q, count_d;
    logic [BITS-1:0]        data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   sck_s, sdi_s, cs_s;
    logic                   sck_rise, cs_fall, cs_rise;

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign busy      = state_q == SHIFT;

    // Equal-depth synchronizers keep sdi aligned with sck; one extra delay reg gives edges
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sck_dly_d  = sck_s;
        cs_dly_d   = cs_s;
    end

    // Frame FSM: cs_n edges take priority over a coincident sck rise
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d = SHIFT;
                shift_d = '0;
                count_d = '0;
            end
        end else if (cs_rise) begin
            state_d = IDLE;
            if (count_q == CW'(BITS)) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (sck_rise) begin
            shift_d = {shift_q[BITS-2:0], sdi_s};
            count_d = (count_q == CW'(BITS + 1)) ? count_q : count_q + CW'(1);
        end
    end

    // State registers; cs_n chain resets high so a held-low cs_n opens a frame after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_dly_q  <= 1'b0;
            cs_dly_q   <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_dly_q  <= sck_dly_d;
            cs_dly_q   <= cs_dly_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_spi_word_receiver.sv
// tb_spi_word_receiver: directed frames against 16-bit and 12-bit receivers
module tb_spi_word_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        cs16 = 1'b1;
    logic        cs12 = 1'b1;
    logic [15:0] data16;
    logic [11:0] data12;
    logic        valid16, err16, busy16, valid12, err12, busy12;
    int          total = 0;
    int          bad = 0;
    int          nv16 = 0, ne16 = 0, nv12 = 0, ne12 = 0;

    spi_word_receiver #(.BITS(16), .SYNC_STAGES(2)) u16 (
        .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .cs_n(cs16),
        .data(data16), .valid(valid16), .frame_err(err16), .busy(busy16)
    );

    spi_word_receiver #(.BITS(12), .SYNC_STAGES(2)) u12 (
        .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .cs_n(cs12),
        .data(data12), .valid(valid12), .frame_err(err12), .busy(busy12)
    );

    always #5 clk = ~clk;

    // Pulse tallies catch any extra or missing valid/frame_err pulse
    always @(negedge clk) begin
        nv16 += int'(valid16);
        ne16 += int'(err16);
        nv12 += int'(valid12);
        ne12 += int'(err12);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cnts(input string tag, input int v16, input int e16, input int v12, input int e12);
        @(posedge clk);
        chk({tag, "_nv16"}, nv16, v16);
        chk({tag, "_ne16"}, ne16, e16);
        chk({tag, "_nv12"}, nv12, v12);
        chk({tag, "_ne12"}, ne12, e12);
        @(negedge clk);
    endtask

    task automatic open_frame(input bit sel);
        if (sel) cs12 = 1'b0;
        else cs16 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bits(input int n, input logic [16:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = v[i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic close_frame(input bit sel, input logic expv, input logic expe, input string tag);
        if (sel) cs12 = 1'b1;
        else cs16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_busy_hold"}, sel ? busy12 : busy16, 1);
        chk({tag, "_early"}, sel ? {valid12, err12} : {valid16, err16}, 0);
        @(negedge clk);
        chk({tag, "_valid"}, sel ? valid12 : valid16, expv);
        chk({tag, "_err"}, sel ? err12 : err16, expe);
        chk({tag, "_busy_drop"}, sel ? busy12 : busy16, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data16", data16, 0);
        chk("rst_flags16", {valid16, err16, busy16}, 0);
        chk("rst_data12", data12, 0);
        chk("rst_flags12", {valid12, err12, busy12}, 0);
        rst = 1'b0;
        @(negedge clk);

        open_frame(0);
        chk("t1_busy", busy16, 1);
        shift_bits(16, 17'h0A5C3);
        close_frame(0, 1'b1, 1'b0, "t1");
        chk("t1_data", data16, 16'hA5C3);
        cnts("t1", 1, 0, 0, 0);

        open_frame(0);
        shift_bits(15, 17'h07FFF);
        close_frame(0, 1'b0, 1'b1, "t2");
        chk("t2_data", data16, 16'hA5C3);
        cnts("t2", 1, 1, 0, 0);

        open_frame(0);
        shift_bits(17, 17'h1FFFF);
        close_frame(0, 1'b0, 1'b1, "t3");
        chk("t3_data", data16, 16'hA5C3);
        cnts("t3", 1, 2, 0, 0);

        open_frame(0);
        shift_bits(16, 17'h0FFFF);
        close_frame(0, 1'b1, 1'b0, "t4a");
        chk("t4a_data", data16, 16'hFFFF);
        open_frame(0);
        shift_bits(16, 17'h00001);
        close_frame(0, 1'b1, 1'b0, "t4b");
        chk("t4b_data", data16, 16'h0001);
        cnts("t4", 3, 2, 0, 0);

        open_frame(0);
        shift_bits(8, 17'h00012);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cs16 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_rst_data", data16, 0);
        chk("t5_rst_busy", busy16, 0);
        cnts("t5_rst", 3, 2, 0, 0);
        open_frame(0);
        shift_bits(16, 17'h01234);
        close_frame(0, 1'b1, 1'b0, "t5");
        chk("t5_data", data16, 16'h1234);
        cnts("t5", 4, 2, 0, 0);

        repeat (5) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("t6_idle_busy", busy12, 0);
        chk("t6_idle_data", data12, 0);
        cnts("t6_idle", 4, 2, 0, 0);
        open_frame(1);
        shift_bits(12, 17'h00ABC);
        close_frame(1, 1'b1, 1'b0, "t6");
        chk("t6_data", data12, 12'hABC);
        chk("t6_data16_kept", data16, 16'h1234);
        cnts("t6", 4, 2, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
